// File: rtl/opcode_inject.sv
// Z80 trap opcode injector: forces CALL TRAP_VECTOR onto the data bus at the next instruction fetch.
// Optional watchdog abort when INJECT_WATCHDOG_EN is defined.
module opcode_inject #(
    parameter logic [15:0] TRAP_VECTOR = 16'h0066,
    parameter logic [7:0]  TIMEOUT     = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic       new_isr,
    input  logic       trap_req,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       mem_inhibit,
    output logic       busy,
    output logic       trap_ack,
    output logic       inject_err
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        OPC,
        LO,
        HI
    } state_t;

    state_t state, state_n;

    // [0],[1] synchronize; [2] holds the previous synchronized value
    logic [2:0] m1_sy;
    logic [2:0] mreq_sy;
    logic [2:0] rd_sy;
    logic [1:0] nisr_sy;

    logic m1_fall;
    logic rd_end;
    logic nisr;
    logic inj;
    logic wd_hit;
    logic ack_set;
    logic req_low_seen;
    logic ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_sy   <= 3'b111;
            mreq_sy <= 3'b111;
            rd_sy   <= 3'b111;
            nisr_sy <= 2'b00;
        end else begin
            m1_sy   <= {m1_sy[1:0], m1_n};
            mreq_sy <= {mreq_sy[1:0], mreq_n};
            rd_sy   <= {rd_sy[1:0], rd_n};
            nisr_sy <= {nisr_sy[0], new_isr};
        end
    end

    assign m1_fall = m1_sy[2] & ~m1_sy[1];
    // MREQ and RD rise together at the end of a read, so use MREQ aligned with the old RD
    assign rd_end  = ~rd_sy[2] & rd_sy[1] & ~mreq_sy[2];
    assign nisr    = nisr_sy[1];
    assign inj     = (state == OPC) || (state == LO) || (state == HI);

`ifdef INJECT_WATCHDOG_EN
    logic [7:0] wd_cnt;
    logic       err_q;

    assign wd_hit = inj && (wd_cnt == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wd_hit & ~rd_end;
            if (state_n != state) begin
                wd_cnt <= 8'd0;
            end else if (inj) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    assign inject_err = err_q;
`else
    assign wd_hit     = 1'b0;
    assign inject_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ack_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (trap_req && req_low_seen) state_n = ARMED;
            end
            ARMED: begin
                if (m1_fall && nisr) state_n = OPC;
                else if (!trap_req)  state_n = IDLE;
            end
            OPC: begin
                if (rd_end)      state_n = LO;
                else if (wd_hit) state_n = IDLE;
            end
            LO: begin
                if (rd_end)      state_n = HI;
                else if (wd_hit) state_n = IDLE;
            end
            HI: begin
                if (rd_end) begin
                    state_n = IDLE;
                    ack_set = 1'b1;
                end else if (wd_hit) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ack_q        <= 1'b0;
            req_low_seen <= 1'b1;
        end else begin
            state <= state_n;
            ack_q <= ack_set;
            if (!trap_req) begin
                req_low_seen <= 1'b1;
            end else if (ack_set) begin
                req_low_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        unique case (state)
            OPC:     data_out = 8'hCD;
            LO:      data_out = TRAP_VECTOR[7:0];
            HI:      data_out = TRAP_VECTOR[15:8];
            default: data_out = 8'h00;
        endcase
    end

    // Raw pins here: the synchronized copies are too late for Z80 read data setup
    assign data_oe = ((state == OPC) & ~m1_n |
                      ((state == LO) | (state == HI)) & m1_n) &
                     ~mreq_n & ~rd_n;

    assign mem_inhibit = data_oe;
    assign busy        = (state != IDLE);
    assign trap_ack    = ack_q;

endmodule

// File: tb/tb_opcode_inject.sv
// Bench for opcode_inject: directed scenarios then random bus traffic vs a byte-queue model.
module tb_opcode_inject;

    localparam logic [15:0] TV = 16'h0066;

    logic       clk;
    logic       rst_n;
    logic       m1_n;
    logic       mreq_n;
    logic       rd_n;
    logic       new_isr;
    logic       trap_req;
    logic [7:0] data_out;
    logic       data_oe;
    logic       mem_inhibit;
    logic       busy;
    logic       trap_ack;
    logic       inject_err;

    opcode_inject #(
        .TRAP_VECTOR(TV),
        .TIMEOUT    (8'd16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m1_n       (m1_n),
        .mreq_n     (mreq_n),
        .rd_n       (rd_n),
        .new_isr    (new_isr),
        .trap_req   (trap_req),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .mem_inhibit(mem_inhibit),
        .busy       (busy),
        .trap_ack   (trap_ack),
        .inject_err (inject_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) begin
        if (trap_ack === 1'b1) ack_cnt++;
        if (inject_err === 1'b1) err_cnt++;
    end

    // Reference model: bytes still owed to the CPU, plus request bookkeeping
    logic [7:0] q[$];
    bit req;
    bit low_seen;
    bit armed;
    int acks_exp;
    int errs_exp;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic post();
        chk("busy", {15'd0, busy}, {15'd0, armed || q.size() != 0});
        chk("ack_count", ack_cnt[15:0], acks_exp[15:0]);
        chk("err_count", err_cnt[15:0], errs_exp[15:0]);
    endtask

    task automatic take_byte(input string tag);
        chk(tag, {8'd0, data_out}, {8'd0, q[0]});
        void'(q.pop_front());
        if (q.size() == 0) begin
            acks_exp++;
            low_seen = !req;
        end
    endtask

    task automatic set_req(input bit v);
        req = v;
        if (!v) begin
            low_seen = 1'b1;
            armed = 1'b0;
        end else if (q.size() == 0 && !armed && low_seen) begin
            armed = 1'b1;
        end
        trap_req = v;
        cyc(3);
        post();
    endtask

    task automatic fetch(input bit nisr);
        bit exp_oe;
        if (armed && nisr) begin
            armed = 1'b0;
            q.delete();
            q.push_back(8'hCD);
            q.push_back(TV[7:0]);
            q.push_back(TV[15:8]);
        end
        exp_oe = (q.size() == 3);
        new_isr = nisr;
        m1_n = 1'b0;
        mreq_n = 1'b0;
        rd_n = 1'b0;
        cyc(6);
        chk("fetch_oe", {15'd0, data_oe}, {15'd0, exp_oe});
        chk("fetch_inhibit", {15'd0, mem_inhibit}, {15'd0, exp_oe});
        if (exp_oe) take_byte("fetch_data");
        rd_n = 1'b1;
        mreq_n = 1'b1;
        m1_n = 1'b1;
        new_isr = 1'b0;
        cyc(4);
        mreq_n = 1'b0;
        cyc(3);
        chk("refresh_oe", {15'd0, data_oe}, 16'd0);
        mreq_n = 1'b1;
        cyc(3);
        post();
    endtask

    task automatic mem_read();
        bit exp_oe;
        exp_oe = (q.size() == 1 || q.size() == 2);
        mreq_n = 1'b0;
        rd_n = 1'b0;
        cyc(6);
        chk("read_oe", {15'd0, data_oe}, {15'd0, exp_oe});
        chk("read_inhibit", {15'd0, mem_inhibit}, {15'd0, exp_oe});
        if (exp_oe) take_byte("read_data");
        rd_n = 1'b1;
        mreq_n = 1'b1;
        cyc(4);
        post();
    endtask

    task automatic io_read();
        rd_n = 1'b0;
        cyc(4);
        chk("io_oe", {15'd0, data_oe}, 16'd0);
        rd_n = 1'b1;
        cyc(4);
        post();
    endtask

    task automatic mem_write();
        mreq_n = 1'b0;
        cyc(4);
        chk("write_oe", {15'd0, data_oe}, 16'd0);
        mreq_n = 1'b1;
        cyc(3);
        post();
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        m1_n = 1'b1;
        mreq_n = 1'b1;
        rd_n = 1'b1;
        new_isr = 1'b0;
        trap_req = 1'b0;
        q.delete();
        req = 1'b0;
        low_seen = 1'b1;
        armed = 1'b0;
        acks_exp = 0;
        errs_exp = 0;
        cyc(3);
        chk("rst_data", {8'd0, data_out}, 16'h0000);
        chk("rst_oe", {15'd0, data_oe}, 16'd0);
        chk("rst_inhibit", {15'd0, mem_inhibit}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ack", {15'd0, trap_ack}, 16'd0);
        chk("rst_err", {15'd0, inject_err}, 16'd0);
        rst_n = 1'b1;
        cyc(2);

        // Basic injection: CD 66 00
        set_req(1'b1);
        fetch(1'b1);
        mem_read();
        mem_read();
        chk("basic_acks", ack_cnt[15:0], 16'd1);

        // Held request: no second injection until it drops
        fetch(1'b1);
        mem_read();
        set_req(1'b0);

        // Prefix continuation must not be hit
        set_req(1'b1);
        fetch(1'b0);
        fetch(1'b1);

        // Refresh, I/O and writes ignored while in LO
        io_read();
        mem_write();
        io_read();
        mem_read();
        mem_read();
        chk("prefix_acks", ack_cnt[15:0], 16'd2);
        set_req(1'b0);

        // Reset in the middle of the LO read
        set_req(1'b1);
        fetch(1'b1);
        mreq_n = 1'b0;
        rd_n = 1'b0;
        cyc(6);
        chk("lo_oe_before_rst", {15'd0, data_oe}, 16'd1);
        chk("lo_data_before_rst", {8'd0, data_out}, {8'd0, TV[7:0]});
        rst_n = 1'b0;
        #1;
        chk("rst_async_oe", {15'd0, data_oe}, 16'd0);
        chk("rst_async_inhibit", {15'd0, mem_inhibit}, 16'd0);
        trap_req = 1'b0;
        rd_n = 1'b1;
        mreq_n = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        q.delete();
        req = 1'b0;
        armed = 1'b0;
        low_seen = 1'b1;
        cyc(3);
        post();

`ifdef INJECT_WATCHDOG_EN
        set_req(1'b1);
        fetch(1'b1);
        cyc(20);
        errs_exp++;
        q.delete();
        armed = req && low_seen;
        chk("wd_err_pulse", err_cnt[15:0], 16'd1);
        post();
        set_req(1'b0);
`endif

        // Random bus traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (q.size() != 0) begin
                if (r < 6)      mem_read();
                else if (r < 8) io_read();
                else if (r < 9) mem_write();
                else            set_req($urandom_range(0, 1) == 1);
            end else begin
                if (r < 3)      set_req(!req);
                else if (r < 6) fetch($urandom_range(0, 3) != 0);
                else if (r < 8) mem_read();
                else if (r < 9) io_read();
                else            mem_write();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opcode_inject.md
# opcode_inject

Bus-side opcode injector for the Nabu trap logic. It is the write-side counterpart of the M1 opcode snooper. When the trap controller requests a trap, the block waits for the next M1 fetch that starts a new instruction. It then drives a three-byte `CALL nn` (0xCD, vector low, vector high) onto the Z80 data bus in place of memory, so the CPU vectors into the trap handler with its return address pushed.

## Interface
Parameters:
- `TRAP_VECTOR`, 16'h0066: target address of the injected CALL.
- `TIMEOUT`, 8'd255: watchdog limit in `clk` cycles (used only with `INJECT_WATCHDOG_EN`).

Ports:
- `clk`  in  1  CPLD system clock; must be ≥3× the Z80 clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m1_n`  in  1  Z80 M1 strobe, raw.
- `mreq_n`  in  1  Z80 memory request, raw.
- `rd_n`  in  1  Z80 read strobe, raw.
- `new_isr`  in  1  high when the current M1 fetch begins a new instruction (from the opcode snooper).
- `trap_req`  in  1  level request from the trap controller; held until `trap_ack`.
- `data_out`  out  8  byte to drive onto D[7:0].
- `data_oe`  out  1  tri-state enable for `data_out`.
- `mem_inhibit`  out  1  suppresses RAM/ROM chip selects while injecting.
- `busy`  out  1  high in any state other than IDLE.
- `trap_ack`  out  1  one-`clk` pulse when the injected sequence completes.
- `inject_err`  out  1  one-`clk` pulse on watchdog abort.

## Operation
Synchronization:
- `m1_n`, `mreq_n`, `rd_n` and `new_isr` each pass through a 2-flop synchronizer before reaching the state logic.
- Edges are detected on the synchronized copies:
  - `m1_fall`: synchronized `m1_n` goes 1→0.
  - `rd_end`: synchronized `rd_n` goes 0→1 while synchronized `mreq_n` is 0.

States:
- **IDLE**
  - Enter ARMED when `trap_req`=1 and `req_low_seen`=1.
  - `req_low_seen` sets whenever `trap_req`=0 and clears on `trap_ack`. This stops a held request from retriggering.
  - `req_low_seen` resets to 1.
- **ARMED**
  - On `m1_fall` with synchronized `new_isr`=1, go to OPC.
  - On `m1_fall` with `new_isr`=0 (prefixed-instruction continuation), stay in ARMED.
  - If `trap_req` drops, return to IDLE with no ack.
- **OPC**
  - `data_out`=8'hCD.
  - On `rd_end`, go to LO.
- **LO**
  - `data_out`=`TRAP_VECTOR[7:0]`.
  - On `rd_end`, go to HI.
- **HI**
  - `data_out`=`TRAP_VECTOR[15:8]`.
  - On `rd_end`, go to IDLE and pulse `trap_ack`.

Drive enables (combinational from the raw pins, so they meet Z80 read timing):
- `data_oe` = (state==OPC & ~m1_n | state∈{LO,HI} & m1_n) & ~mreq_n & ~rd_n.
- `mem_inhibit` = `data_oe`.

Cycles that are never driven and never counted:
- Refresh cycles after M1 (`mreq_n`=0, `rd_n`=1).
- Memory writes.
- I/O cycles (`mreq_n`=1).

Once OPC is entered, the sequence is committed: `trap_req` is ignored until HI completes. The later stack-push writes are left to the CPU and memory untouched.

## Timing
- Reset values:
  - state IDLE
  - `data_out`=8'h00
  - `data_oe`=0, `mem_inhibit`=0, `busy`=0, `trap_ack`=0, `inject_err`=0.
- Reset is asynchronous. Asserting it mid-sequence releases `data_oe` and `mem_inhibit` immediately, with no clock needed.
- Synchronizer plus edge detect costs 3 `clk` of latency. ARMED→OPC therefore completes 3 `clk` after M1 falls, before RD reaches T2 of the fetch.
- `busy` is registered; it rises 1 `clk` after `trap_req` is seen with `req_low_seen`=1.
- `trap_ack` is asserted for exactly 1 `clk`, 3 `clk` after `rd_n` rises on the HI read.
- If `trap_req` is released in the same `clk` as `m1_fall` in ARMED, OPC wins and the sequence completes.

## Configuration
- `INJECT_WATCHDOG_EN` defined:
  - An 8-bit counter clears on every state change and counts while in OPC, LO or HI.
  - At `TIMEOUT` the block returns to IDLE, pulses `inject_err` for 1 `clk`, and sends no `trap_ack`.
- `INJECT_WATCHDOG_EN` not defined:
  - No counter is built, and the block waits indefinitely.
  - `inject_err` is tied to 0.

## Test plan
- **Basic injection.** Reset, raise `trap_req`, run fetch (new_isr=1) then two memory reads. Bus must read 0xCD, 0x66, 0x00; `trap_ack` pulses once; `busy` ends at 0.
- **Prefixed-instruction boundary.** With `trap_req`=1, an M1 with new_isr=0 (after CB) must leave D undriven. The next M1 with new_isr=1 must receive 0xCD.
- **Request held after ack.** Keep `trap_req` high past `trap_ack`: no second injection. Drop then re-raise it: a second injection occurs.
- **Reset mid-sequence.** Assert `rst_n`=0 during the LO read. `data_oe` must drop within the same combinational path, and the state must be IDLE with no ack.
- **Refresh and I/O ignored.** Interleave refresh and IN/OUT cycles in LO. The state must stay LO and `data_oe` must stay 0 until the next memory read, which receives 0x66.
- **Watchdog abort.** With `INJECT_WATCHDOG_EN` and TIMEOUT=16, stall in LO for 20 `clk`. `inject_err` must pulse at count 16 and the state must return to IDLE.
